// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and the default operand width.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [2:0] {
      MULT  = 3'b000,
      MULTU = 3'b001,
      DIV   = 3'b010,
      DIVU  = 3'b011,
      MTHI  = 3'b100,
      MTLO  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10
   } state_e;

   function automatic logic op_valid(input logic [2:0] code);
      return code <= 3'd5;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add multiply when
// mode_i=0, restoring divide when mode_i=1. {acc,q} is the working pair.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             mode_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      sum     = {1'b0, acc_i} + {1'b0, b_i};
      shifted = {acc_i, q_i[WIDTH-1]};
      diff    = shifted - {1'b0, b_i};
      if (!mode_i) begin
         // Product shifts right out of the sum; the carry becomes acc's new MSB.
         if (q_i[0]) begin
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
         end else begin
            acc_o = {1'b0, acc_i[WIDTH-1:1]};
            q_o   = {acc_i[0], q_i[WIDTH-1:1]};
         end
      end else if (shifted >= {1'b0, b_i}) begin
         acc_o = diff[WIDTH-1:0];
         q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
         acc_o = shifted[WIDTH-1:0];
         q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: WIDTH iterations on operand
// magnitudes in RUN, then sign correction and HI/LO write-back in FIX.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
   logic               done_q, done_d;

   logic               accept, signed_op, rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag, step_acc, step_q, quot_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_raw, prod_fix;

   assign accept    = start && (state_q == IDLE) && !flush && op_valid(op);
   assign signed_op = (op == MULT) || (op == DIV);
   assign rs_neg    = signed_op && rs[WIDTH-1];
   assign rt_neg    = signed_op && rt[WIDTH-1];
   assign rs_mag    = rs_neg ? -rs : rs;
   assign rt_mag    = rt_neg ? -rt : rt;

   assign prod_raw  = {acc_q, q_q};
   assign prod_fix  = neg_q ? -prod_raw : prod_raw;
   assign quot_fix  = neg_q ? -q_q : q_q;
   assign rem_fix   = rem_neg_q ? -acc_q : acc_q;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode_i (is_div_q),
      .acc_i  (acc_q),
      .q_i    (q_q),
      .b_i    (b_q),
      .acc_o  (step_acc),
      .q_o    (step_q)
   );

   always_comb begin
      // NOTE: every _d gets its hold value first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      q_d       = q_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op_e'(op))
                  MTHI:    hi_d = rs;
                  MTLO:    lo_d = rs;
                  default: begin
                     state_d   = RUN;
                     cnt_d     = '0;
                     acc_d     = '0;
                     q_d       = rs_mag;
                     b_d       = rt_mag;
                     is_div_d  = op[1];
                     // A zero divisor keeps an all-ones quotient regardless of sign.
                     neg_d     = (rs_neg ^ rt_neg) && !(op[1] && (rt == '0));
                     rem_neg_d = rs_neg;
                  end
               endcase
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = step_acc;
               q_d   = step_q;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = FIX;
                  cnt_d   = '0;
               end
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  lo_d = quot_fix;
                  hi_d = rem_fix;
               end else begin
                  {hi_d, lo_d} = prod_fix;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         q_q       <= q_d;
         b_q       <= b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, signed/unsigned
// results, corner divides, ignored requests, flush and mid-operation reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;
   int lat;
   int bcnt;
   int dcnt;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request for exactly one sampling edge; returns in cycle 1 after it.
   task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op    = o;
      rs    = a;
      rt    = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Cycle k is the interval after the k-th edge following the start edge.
   task automatic wait_done(input int first, output int latency, output int busy_cycles);
      latency     = 0;
      busy_cycles = 0;
      for (int k = first; k <= 60; k++) begin
         if (busy) busy_cycles++;
         if (done) begin
            latency = k;
            break;
         end
         tick();
      end
   endtask

   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int k = 0; k < n; k++) begin
         if (done) pulses++;
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'b000;
      rs    = '0;
      rt    = '0;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      #10 rst_n = 1'b1;

      // First edge after release accepts this request.
      start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, lat, bcnt);
      check("multu_latency", 64'(lat), 64'd34);
      check("multu_busy_cycles", 64'(bcnt), 64'd33);
      check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      check("multu_lo", 64'(lo), 64'h0000_0001);
      tick();
      check("done_one_cycle", 64'(done), 64'd0);

      start_op(MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done(1, lat, bcnt);
      check("mult_neg_latency", 64'(lat), 64'd34);
      check("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);

      start_op(DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(1, lat, bcnt);
      check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

      start_op(DIVU, 32'd7, 32'd2);
      wait_done(1, lat, bcnt);
      check("divu_lo", 64'(lo), 64'd3);
      check("divu_hi", 64'(hi), 64'd1);

      start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1, lat, bcnt);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi), 64'd0);

      start_op(DIVU, 32'd5, 32'd0);
      wait_done(1, lat, bcnt);
      check("divu_zero_latency", 64'(lat), 64'd34);
      check("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
      check("divu_zero_hi", 64'(hi), 64'd5);

      start_op(DIV, 32'hFFFF_FFF8, 32'd0);
      wait_done(1, lat, bcnt);
      check("div_zero_lo", 64'(lo), 64'hFFFF_FFFF);
      check("div_zero_hi", 64'(hi), 64'hFFFF_FFF8);

      // Requests arriving while busy are dropped without queueing.
      start_op(MULTU, 32'd3, 32'd4);
      repeat (4) tick();
      start_op(DIVU, 32'd100, 32'd3);
      start_op(MTHI, 32'h0000_DEAD, 32'd0);
      wait_done(7, lat, bcnt);
      check("ignore_latency", 64'(lat), 64'd34);
      check("ignore_hi", 64'(hi), 64'd0);
      check("ignore_lo", 64'(lo), 64'd12);

      // Back-to-back: the done cycle accepts the next request.
      start_op(MULTU, 32'd5, 32'd6);
      wait_done(1, lat, bcnt);
      check("b2b_latency", 64'(lat), 64'd34);
      check("b2b_lo", 64'(lo), 64'd30);
      tick();

      start_op(3'b110, 32'h1234_5678, 32'd1);
      check("reserved_busy", 64'(busy), 64'd0);
      check("reserved_lo", 64'(lo), 64'd30);

      start_op(MTHI, 32'h0000_AAAA, 32'd0);
      check("mthi_hi", 64'(hi), 64'h0000_AAAA);
      check("mthi_busy", 64'(busy), 64'd0);
      check("mthi_done", 64'(done), 64'd0);
      start_op(MTLO, 32'h0000_5555, 32'd0);
      check("mtlo_lo", 64'(lo), 64'h0000_5555);

      start_op(DIVU, 32'd9, 32'd2);
      repeat (8) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      check("flush_hi", 64'(hi), 64'h0000_AAAA);
      check("flush_lo", 64'(lo), 64'h0000_5555);
      count_done(40, dcnt);
      check("flush_no_done", 64'(dcnt), 64'd0);

      flush = 1'b1;
      start_op(MULTU, 32'd2, 32'd2);
      flush = 1'b0;
      check("flush_beats_start", 64'(busy), 64'd0);

      start_op(MULTU, 32'd3, 32'd4);
      repeat (9) tick();
      check("pre_reset_busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_hi", 64'(hi), 64'd0);
      check("async_rst_lo", 64'(lo), 64'd0);
      tick();
      #2 rst_n = 1'b1;
      count_done(40, dcnt);
      check("rst_no_done", 64'(dcnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
